// File: rtl/sc_game_pkg.sv
// -----------------------------------------------------------------------------
// sc_game_pkg
// Shared types and constants for the RoadFighter game-flow sequencer:
//   - state_t      : sequencer state encoding
//   - SEL_*        : screen-mux select codes (PLAY and PAUSE share a code, the
//                    mux shows a frozen frame while paused)
//   - LIVES_W/LEVEL_W : widths of the lives and level outputs
//   - select_code(): maps a state to its screen-mux code
// -----------------------------------------------------------------------------
package sc_game_pkg;

    localparam int LIVES_W = 4;
    localparam int LEVEL_W = 4;
    localparam int CODE_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_CRASH     = 3'd4,
        ST_LEVELUP   = 3'd5,
        ST_GAMEOVER  = 3'd6
    } state_t;

    localparam logic [CODE_W-1:0] SEL_IDLE      = 3'd0;
    localparam logic [CODE_W-1:0] SEL_COUNTDOWN = 3'd1;
    localparam logic [CODE_W-1:0] SEL_PLAY      = 3'd2;
    localparam logic [CODE_W-1:0] SEL_CRASH     = 3'd3;
    localparam logic [CODE_W-1:0] SEL_LEVELUP   = 3'd4;
    localparam logic [CODE_W-1:0] SEL_GAMEOVER  = 3'd5;

    function automatic logic [CODE_W-1:0] select_code(input state_t s);
        case (s)
            ST_COUNTDOWN: select_code = SEL_COUNTDOWN;
            ST_PLAY:      select_code = SEL_PLAY;
            ST_PAUSE:     select_code = SEL_PLAY;
            ST_CRASH:     select_code = SEL_CRASH;
            ST_LEVELUP:   select_code = SEL_LEVELUP;
            ST_GAMEOVER:  select_code = SEL_GAMEOVER;
            default:      select_code = SEL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sc_button_edge.sv
// -----------------------------------------------------------------------------
// sc_button_edge
// Falling-edge detector for an active-low, already synchronous button.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn_n : button level, active-low
//   fall  : high in the cycle whose sample shows 1 -> 0
// The history register resets to 1, and the first sample after reset only
// loads history, so a button held low through reset release gives no event.
// -----------------------------------------------------------------------------
module sc_button_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic fall
);

    logic prev_q;
    logic armed_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= btn_n;
            armed_q <= 1'b1;
        end
    end

    assign fall = armed_q & prev_q & ~btn_n;

endmodule

// File: rtl/sc_game_sequencer.sv
// -----------------------------------------------------------------------------
// sc_game_sequencer
// Tick-timed game-flow FSM: idle, countdown, play, pause, crash, level-up and
// game-over. Tracks lives, level and distance; all outputs are registered.
//   SC_GAMESEQ_CLOCK_50       : system clock
//   SC_GAMESEQ_RESET_InHigh   : asynchronous active-high reset
//   SC_GAMESEQ_START_InLow    : start button (falling edge acts)
//   SC_GAMESEQ_PAUSE_InLow    : pause button (falling edge toggles pause)
//   SC_GAMESEQ_TICK_InHigh    : one-cycle time-base pulse
//   SC_GAMESEQ_CRASH_InHigh   : collision level from the playfield
//   SC_GAMESEQ_SELECT_OutBUS  : screen-mux select (code of current state)
//   SC_GAMESEQ_COUNT_OutBUS   : remaining ticks (COUNTDOWN/CRASH/LEVELUP) or
//                               distance (PLAY/PAUSE)
//   SC_GAMESEQ_LIVES_OutBUS   : lives remaining
//   SC_GAMESEQ_LEVEL_OutBUS   : current level, 1-based
//   SC_GAMESEQ_RUN_OutHigh    : high only in PLAY
//   SC_GAMESEQ_CLEAR_OutHigh  : one-cycle pulse after entering COUNTDOWN
//   SC_GAMESEQ_WIN_OutHigh    : game over with all levels completed
// -----------------------------------------------------------------------------
module sc_game_sequencer
    import sc_game_pkg::*;
#(
    parameter int SELECT_WIDTH    = 3,
    parameter int COUNT_WIDTH     = 8,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int CRASH_TICKS     = 2,
    parameter int LIVES           = 3,
    parameter int GOAL_TICKS      = 8,
    parameter int LEVELS          = 2
) (
    input  logic                    SC_GAMESEQ_CLOCK_50,
    input  logic                    SC_GAMESEQ_RESET_InHigh,
    input  logic                    SC_GAMESEQ_START_InLow,
    input  logic                    SC_GAMESEQ_PAUSE_InLow,
    input  logic                    SC_GAMESEQ_TICK_InHigh,
    input  logic                    SC_GAMESEQ_CRASH_InHigh,
    output logic [SELECT_WIDTH-1:0] SC_GAMESEQ_SELECT_OutBUS,
    output logic [COUNT_WIDTH-1:0]  SC_GAMESEQ_COUNT_OutBUS,
    output logic [LIVES_W-1:0]      SC_GAMESEQ_LIVES_OutBUS,
    output logic [LEVEL_W-1:0]      SC_GAMESEQ_LEVEL_OutBUS,
    output logic                    SC_GAMESEQ_RUN_OutHigh,
    output logic                    SC_GAMESEQ_CLEAR_OutHigh,
    output logic                    SC_GAMESEQ_WIN_OutHigh
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_CD     = COUNT_WIDTH'(COUNTDOWN_TICKS);
    localparam logic [COUNT_WIDTH-1:0] CNT_CRASH  = COUNT_WIDTH'(CRASH_TICKS);
    localparam logic [COUNT_WIDTH-1:0] CNT_GOAL   = COUNT_WIDTH'(GOAL_TICKS);
    localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LEVEL_W-1:0]     LEVEL_LAST = LEVEL_W'(LEVELS);

    logic clk;
    logic rst;
    logic tick;
    logic crash;
    logic start_ev;
    logic pause_ev;

    assign clk   = SC_GAMESEQ_CLOCK_50;
    assign rst   = SC_GAMESEQ_RESET_InHigh;
    assign tick  = SC_GAMESEQ_TICK_InHigh;
    assign crash = SC_GAMESEQ_CRASH_InHigh;

    sc_button_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .btn_n (SC_GAMESEQ_START_InLow),
        .fall  (start_ev)
    );

    sc_button_edge u_pause_edge (
        .clk   (clk),
        .rst   (rst),
        .btn_n (SC_GAMESEQ_PAUSE_InLow),
        .fall  (pause_ev)
    );

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [LIVES_W-1:0]       lives_q, lives_d;
    logic [LEVEL_W-1:0]       level_q, level_d;
    logic                     win_q, win_d;
    logic [SELECT_WIDTH-1:0]  select_q;
    logic                     run_q;
    logic                     clear_q;

    // NOTE: every next-state variable gets its hold value before the case, so
    // no path through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lives_d = lives_q;
        level_d = level_q;
        win_d   = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_d = ST_COUNTDOWN;
                    lives_d = LIVES_INIT;
                    level_d = LEVEL_W'(1);
                    count_d = CNT_CD;
                end
            end

            ST_COUNTDOWN: begin
                if (tick) begin
                    if (count_q == CNT_ONE) begin
                        state_d = ST_PLAY;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            ST_PLAY: begin
                // Crash beats pause, pause beats the distance tick.
                if (crash) begin
                    state_d = ST_CRASH;
                    count_d = CNT_CRASH;
                end else if (pause_ev) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (count_q + CNT_ONE == CNT_GOAL) begin
                        state_d = ST_LEVELUP;
                        count_d = CNT_CRASH;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end

            ST_PAUSE: begin
                if (pause_ev) begin
                    state_d = ST_PLAY;
                end
            end

            ST_CRASH: begin
                if (tick) begin
                    if (count_q == CNT_ONE) begin
                        if (lives_q == LIVES_W'(1)) begin
                            state_d = ST_GAMEOVER;
                            lives_d = '0;
                            win_d   = 1'b0;
                            count_d = '0;
                        end else begin
                            state_d = ST_COUNTDOWN;
                            lives_d = lives_q - LIVES_W'(1);
                            count_d = CNT_CD;
                        end
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            ST_LEVELUP: begin
                if (tick) begin
                    if (count_q == CNT_ONE) begin
                        if (level_q == LEVEL_LAST) begin
                            state_d = ST_GAMEOVER;
                            win_d   = 1'b1;
                            count_d = '0;
                        end else begin
                            state_d = ST_COUNTDOWN;
                            level_d = level_q + LEVEL_W'(1);
                            count_d = CNT_CD;
                        end
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            ST_GAMEOVER: begin
                if (start_ev) begin
                    state_d = ST_IDLE;
                    win_d   = 1'b0;
                    count_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Output registers are loaded from the next state, so select/run/clear
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            lives_q  <= '0;
            level_q  <= '0;
            win_q    <= 1'b0;
            select_q <= '0;
            run_q    <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            win_q    <= win_d;
            select_q <= SELECT_WIDTH'(select_code(state_d));
            run_q    <= (state_d == ST_PLAY);
            clear_q  <= (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);
        end
    end

    assign SC_GAMESEQ_SELECT_OutBUS = select_q;
    assign SC_GAMESEQ_COUNT_OutBUS  = count_q;
    assign SC_GAMESEQ_LIVES_OutBUS  = lives_q;
    assign SC_GAMESEQ_LEVEL_OutBUS  = level_q;
    assign SC_GAMESEQ_RUN_OutHigh   = run_q;
    assign SC_GAMESEQ_CLEAR_OutHigh = clear_q;
    assign SC_GAMESEQ_WIN_OutHigh   = win_q;

endmodule

// File: tb/tb_sc_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sc_game_sequencer
// Directed game scenarios with literal expectations, followed by randomized
// button/crash activity. A behavioural game model is compared against the DUT
// on every clock outside reset.
// -----------------------------------------------------------------------------
module tb_sc_game_sequencer;

    localparam int T_CD     = 3;
    localparam int T_CRASH  = 2;
    localparam int T_LIVES  = 3;
    localparam int T_GOAL   = 8;
    localparam int T_LEVELS = 2;

    localparam int P_IDLE  = 0;
    localparam int P_CD    = 1;
    localparam int P_PLAY  = 2;
    localparam int P_PAUSE = 3;
    localparam int P_CRASH = 4;
    localparam int P_LVL   = 5;
    localparam int P_OVER  = 6;

    logic       clk;
    logic       rst;
    logic       start_n;
    logic       pause_n;
    logic       tick;
    logic       crash;
    logic [2:0] sel;
    logic [7:0] count;
    logic [3:0] lives;
    logic [3:0] level;
    logic       run;
    logic       clear;
    logic       win;

    int tests  = 0;
    int failed = 0;
    int model_fail_prints = 0;

    sc_game_sequencer #(
        .SELECT_WIDTH    (3),
        .COUNT_WIDTH     (8),
        .COUNTDOWN_TICKS (T_CD),
        .CRASH_TICKS     (T_CRASH),
        .LIVES           (T_LIVES),
        .GOAL_TICKS      (T_GOAL),
        .LEVELS          (T_LEVELS)
    ) dut (
        .SC_GAMESEQ_CLOCK_50      (clk),
        .SC_GAMESEQ_RESET_InHigh  (rst),
        .SC_GAMESEQ_START_InLow   (start_n),
        .SC_GAMESEQ_PAUSE_InLow   (pause_n),
        .SC_GAMESEQ_TICK_InHigh   (tick),
        .SC_GAMESEQ_CRASH_InHigh  (crash),
        .SC_GAMESEQ_SELECT_OutBUS (sel),
        .SC_GAMESEQ_COUNT_OutBUS  (count),
        .SC_GAMESEQ_LIVES_OutBUS  (lives),
        .SC_GAMESEQ_LEVEL_OutBUS  (level),
        .SC_GAMESEQ_RUN_OutHigh   (run),
        .SC_GAMESEQ_CLEAR_OutHigh (clear),
        .SC_GAMESEQ_WIN_OutHigh   (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time base: a one-cycle tick every 4 clocks.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // ---------------------------------------------------------------- model
    typedef struct {
        int ph;
        int cnt;
        int lives;
        int level;
        bit win;
        bit clr;
        bit sp;
        bit pp;
        bit armed;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.ph = P_IDLE; r.cnt = 0; r.lives = 0; r.level = 0;
        r.win = 1'b0; r.clr = 1'b0; r.sp = 1'b1; r.pp = 1'b1; r.armed = 1'b0;
        return r;
    endfunction

    // One clock of game rules, applied to the sampled inputs.
    function automatic model_t model_next(model_t c, bit s_n, bit p_n, bit tk, bit cr);
        model_t n;
        bit s_ev;
        bit p_ev;
        n = c;
        n.clr = 1'b0;
        s_ev = c.armed && c.sp && !s_n;
        p_ev = c.armed && c.pp && !p_n;
        case (c.ph)
            P_IDLE: if (s_ev) begin
                n.ph = P_CD; n.lives = T_LIVES; n.level = 1; n.cnt = T_CD; n.clr = 1'b1;
            end
            P_CD: if (tk) begin
                n.cnt = c.cnt - 1;
                if (n.cnt == 0) n.ph = P_PLAY;
            end
            P_PLAY: begin
                if (cr) begin
                    n.ph = P_CRASH; n.cnt = T_CRASH;
                end else if (p_ev) begin
                    n.ph = P_PAUSE;
                end else if (tk) begin
                    n.cnt = c.cnt + 1;
                    if (n.cnt == T_GOAL) begin n.ph = P_LVL; n.cnt = T_CRASH; end
                end
            end
            P_PAUSE: if (p_ev) n.ph = P_PLAY;
            P_CRASH: if (tk) begin
                n.cnt = c.cnt - 1;
                if (n.cnt == 0) begin
                    n.lives = c.lives - 1;
                    if (n.lives == 0) begin
                        n.ph = P_OVER; n.win = 1'b0;
                    end else begin
                        n.ph = P_CD; n.cnt = T_CD; n.clr = 1'b1;
                    end
                end
            end
            P_LVL: if (tk) begin
                n.cnt = c.cnt - 1;
                if (n.cnt == 0) begin
                    if (c.level == T_LEVELS) begin
                        n.ph = P_OVER; n.win = 1'b1;
                    end else begin
                        n.level = c.level + 1; n.ph = P_CD; n.cnt = T_CD; n.clr = 1'b1;
                    end
                end
            end
            default: if (s_ev) begin
                n.ph = P_IDLE; n.win = 1'b0; n.cnt = 0;
            end
        endcase
        n.sp = s_n;
        n.pp = p_n;
        n.armed = 1'b1;
        return n;
    endfunction

    function automatic int sel_of(int ph);
        case (ph)
            P_CD:              return 1;
            P_PLAY, P_PAUSE:   return 2;
            P_CRASH:           return 3;
            P_LVL:             return 4;
            P_OVER:            return 5;
            default:           return 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m, start_n, pause_n, tick, crash);
    end

    // Compare process: every cycle outside reset, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            tests++;
            if (sel !== 3'(sel_of(m.ph)) || count !== 8'(m.cnt) ||
                lives !== 4'(m.lives) || level !== 4'(m.level) ||
                run !== (m.ph == P_PLAY) || clear !== m.clr || win !== m.win) begin
                failed++;
                if (model_fail_prints < 20) begin
                    model_fail_prints++;
                    $display("FAIL model t=%0t: got sel=%0d cnt=%0d lives=%0d lvl=%0d run=%0b clr=%0b win=%0b, required sel=%0d cnt=%0d lives=%0d lvl=%0d run=%0b clr=%0b win=%0b",
                             $time, sel, count, lives, level, run, clear, win,
                             sel_of(m.ph), m.cnt, m.lives, m.level, (m.ph == P_PLAY), m.clr, m.win);
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Returns at the negedge after the next tick edge.
    task automatic wait_tick();
        int n;
        n = 0;
        @(posedge clk);
        while (!tick && n < 16) begin
            @(posedge clk);
            n++;
        end
        if (!tick) begin
            tests++;
            failed++;
            $display("FAIL tick_timeout: got no tick, required one within 16 clocks");
        end
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) wait_tick();
    endtask

    // One-cycle press; returns at the negedge after the edge that sees it.
    task automatic press_start();
        @(posedge clk); #1 start_n = 1'b0;
        @(posedge clk); #1 start_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press_pause();
        @(posedge clk); #1 pause_n = 1'b0;
        @(posedge clk); #1 pause_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic crash_pulse();
        @(posedge clk); #1 crash = 1'b1;
        @(posedge clk); #1 crash = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1; start_n = 1'b0; pause_n = 1'b1; crash = 1'b0;

        // Reset while START is held low: no transition.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("held_sel",   32'(sel),   0);
        check("held_count", 32'(count), 0);
        check("held_lives", 32'(lives), 0);
        @(posedge clk); #1 start_n = 1'b1;
        repeat (3) @(negedge clk);
        check("release_sel", 32'(sel), 0);

        // Start and countdown.
        press_start();
        check("start_clear", 32'(clear), 1);
        check("start_sel",   32'(sel),   1);
        check("start_lives", 32'(lives), 3);
        check("start_level", 32'(level), 1);
        check("start_count", 32'(count), 3);
        @(negedge clk);
        check("clear_one_cycle", 32'(clear), 0);
        wait_tick(); check("cd_count_2", 32'(count), 2);
        wait_tick(); check("cd_count_1", 32'(count), 1);
        wait_tick();
        check("play_sel",   32'(sel),   2);
        check("play_run",   32'(run),   1);
        check("play_count", 32'(count), 0);

        // Pause at distance 4.
        wait_ticks(4);
        check("dist_4", 32'(count), 4);
        press_pause();
        check("pause_sel", 32'(sel), 2);
        check("pause_run", 32'(run), 0);
        wait_ticks(10);
        check("pause_hold_count", 32'(count), 4);
        press_pause();
        check("resume_run",   32'(run),   1);
        check("resume_count", 32'(count), 4);
        wait_tick();
        check("dist_5", 32'(count), 5);

        // Crash together with a tick at distance 5.
        repeat (3) @(posedge clk);
        #2 crash = 1'b1;
        check("tick_aligned", 32'(tick), 1);
        @(posedge clk); #1 crash = 1'b0;
        @(negedge clk);
        check("crash_sel",   32'(sel),   3);
        check("crash_count", 32'(count), 2);
        wait_ticks(2);
        check("crash1_sel",   32'(sel),   1);
        check("crash1_lives", 32'(lives), 2);
        check("crash1_clear", 32'(clear), 1);
        check("crash1_count", 32'(count), 3);
        wait_ticks(3);
        crash_pulse();
        wait_ticks(2);
        check("crash2_lives", 32'(lives), 1);
        wait_ticks(3);
        crash_pulse();
        wait_ticks(2);
        check("over_sel",   32'(sel),   5);
        check("over_lives", 32'(lives), 0);
        check("over_win",   32'(win),   0);
        press_start();
        check("over_to_idle", 32'(sel), 0);

        // Level progression to a win.
        press_start();
        wait_ticks(3 + 8);
        check("levelup_sel", 32'(sel), 4);
        wait_ticks(2);
        check("level2_level", 32'(level), 2);
        check("level2_sel",   32'(sel),   1);
        wait_ticks(3 + 8 + 2);
        check("win_sel",   32'(sel),   5);
        check("win_win",   32'(win),   1);
        check("win_level", 32'(level), 2);
        press_start();
        check("win_idle_sel", 32'(sel), 0);
        check("win_idle_win", 32'(win), 0);

        // Asynchronous reset in the middle of CRASH.
        press_start();
        wait_ticks(3);
        crash_pulse();
        wait_tick();
        check("pre_rst_sel", 32'(sel), 3);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("arst_sel",   32'(sel),   0);
        check("arst_count", 32'(count), 0);
        check("arst_lives", 32'(lives), 0);
        check("arst_level", 32'(level), 0);
        check("arst_run",   32'(run),   0);
        check("arst_clear", 32'(clear), 0);
        check("arst_win",   32'(win),   0);
        @(posedge clk); #1 rst = 1'b0;

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start_n = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            pause_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            crash   = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
        end
        @(posedge clk); #1 start_n = 1'b1; pause_n = 1'b1; crash = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sc_game_sequencer.md
# sc_game_sequencer

Parametrised game-flow sequencer for the RoadFighter top level. It drives the screen-mux select and the gameplay enables through a complete game: idle screen, countdown, play, pause, crash, level-up and game-over. It runs from the system time-base tick and the player buttons. It replaces the earlier two-code select logic with a registered, tick-timed FSM that also tracks lives, level and distance.

## Interface
- SELECT_WIDTH, 3 — width of the screen-mux select bus; must be ≥3.
- COUNT_WIDTH, 8 — width of the internal tick counter and the count output.
- COUNTDOWN_TICKS, 3 — ticks spent in COUNTDOWN; range 1..2^COUNT_WIDTH-1.
- CRASH_TICKS, 2 — ticks spent in CRASH and in LEVELUP; range ≥1.
- LIVES, 3 — lives at game start; range 1..15.
- GOAL_TICKS, 8 — PLAY ticks needed to complete a level; range ≥1.
- LEVELS, 2 — number of levels in a game; range 1..15.
- SC_GAMESEQ_CLOCK_50 in 1 — system clock.
- SC_GAMESEQ_RESET_InHigh in 1 — asynchronous, active-high reset.
- SC_GAMESEQ_START_InLow in 1 — start button, active-low, already debounced and synchronous; acts on its falling edge.
- SC_GAMESEQ_PAUSE_InLow in 1 — pause button, active-low; its falling edge toggles pause.
- SC_GAMESEQ_TICK_InHigh in 1 — one-cycle time-base pulse.
- SC_GAMESEQ_CRASH_InHigh in 1 — collision level from the playfield.
- SC_GAMESEQ_SELECT_OutBUS out SELECT_WIDTH — screen-mux select.
- SC_GAMESEQ_COUNT_OutBUS out COUNT_WIDTH — remaining ticks in COUNTDOWN, CRASH and LEVELUP; distance in PLAY and PAUSE.
- SC_GAMESEQ_LIVES_OutBUS out 4 — lives remaining.
- SC_GAMESEQ_LEVEL_OutBUS out 4 — current level, 1-based.
- SC_GAMESEQ_RUN_OutHigh out 1 — high only in PLAY; enables scrolling and the traffic generator.
- SC_GAMESEQ_CLEAR_OutHigh out 1 — one-cycle playfield-clear pulse.
- SC_GAMESEQ_WIN_OutHigh out 1 — set in GAMEOVER when all levels are completed.

## Operation
- **States and select codes:** IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=2 (frozen frame), CRASH=3, LEVELUP=4, GAMEOVER=5. The select output is registered and equals the code of the current state.
- **Edge detection:**
  - start_ev = previous sample 1 and current sample 0; pause_ev is derived the same way.
  - The previous-sample registers reset to 1, so a button held through reset release produces no event.
- **IDLE:** on start_ev → COUNTDOWN; lives←LIVES, level←1, count←COUNTDOWN_TICKS, CLEAR pulse.
- **COUNTDOWN:** each tick decrements count. A tick with count==1 → PLAY, count←0. Pause and crash are ignored.
- **PLAY:** the following priorities apply in the same cycle, highest first.
  - crash → CRASH, count←CRASH_TICKS.
  - pause_ev → PAUSE.
  - tick → count+1; if count+1==GOAL_TICKS → LEVELUP, count←CRASH_TICKS.
- **PAUSE:** count and all counters are held, and ticks and crash are ignored. pause_ev → PLAY; start_ev is ignored.
- **CRASH:** each tick decrements count. On a tick with count==1:
  - if lives==1: lives←0 → GAMEOVER, WIN←0;
  - otherwise: lives−1 → COUNTDOWN, count←COUNTDOWN_TICKS, CLEAR pulse. Distance restarts from 0.
- **LEVELUP:** each tick decrements count. On a tick with count==1:
  - if level==LEVELS: → GAMEOVER, WIN←1;
  - otherwise: level+1 → COUNTDOWN, count←COUNTDOWN_TICKS, CLEAR pulse.
- **GAMEOVER:** select=5 and lives, level and WIN are held. start_ev → IDLE with WIN←0, count←0.
- **Arithmetic:** all counters are unsigned. The rules above mean count never underflows and never wraps past GOAL_TICKS.
- **Undefined state encodings** → IDLE on the next clock.

## Timing
- **Reset values:**
  - SELECT=0 (IDLE), COUNT=0, LIVES=0, LEVEL=0, RUN=0, CLEAR=0, WIN=0.
  - Button history registers are 1.
- **Reset mid-game** returns to these values immediately; no CLEAR pulse is issued.
- **Latency:** all outputs are registered. An event sampled at clock edge k appears on the outputs after edge k, a single-cycle response. RUN tracks the state in that same cycle.
- **CLEAR** is high for exactly the one cycle after the transition edge into COUNTDOWN.
- **Tick and button events in the same cycle** are both evaluated; the per-state priorities above resolve them.
- **A tick arriving on the cycle of entry** into a timed state is not counted; counting starts on the next tick.

## Structure
- Shared package sc_game_pkg holds:
  - the state enum and the select-code constants;
  - the lives and level widths (4).
- One sub-module, sc_button_edge: a registered falling-edge detector with the history register reset to 1. It is instantiated twice, for start and pause.
- The FSM, counters and output registers live in sc_game_sequencer.

## Test plan
All scenarios use the default parameters and a tick every 4 clocks.
- **Reset while held:** hold START low through reset release → no transition; SELECT=0, COUNT=0, LIVES=0.
- **Start and countdown:** START falls in IDLE → CLEAR for 1 cycle; SELECT=1, LIVES=3, LEVEL=1, COUNT=3. COUNT goes 3→2→1, and the 3rd tick gives SELECT=2, RUN=1, COUNT=0.
- **Pause:** in PLAY at COUNT=4, PAUSE falls → SELECT=2, RUN=0. 10 ticks later COUNT is still 4; a second PAUSE fall restores RUN=1.
- **Crash priority:** crash and tick in the same cycle at COUNT=5 → SELECT=3, COUNT=2. Two ticks later → SELECT=1, LIVES=2, CLEAR pulse. Three crash cycles in total → SELECT=5, LIVES=0, WIN=0.
- **Level progression:**
  - 8 PLAY ticks → SELECT=4.
  - 2 ticks later → LEVEL=2, SELECT=1.
  - After completing level 2 → SELECT=5, WIN=1.
  - A START fall then gives SELECT=0, WIN=0.
- **Async reset mid-CRASH:** RESET high → all outputs at reset values within the same cycle, without waiting for a clock edge.
